// File: rtl/reg8_rr_arbiter.sv
// reg8_rr_arbiter: round-robin write arbiter in front of a shared W-bit register.
// Requesters win in rotating order starting at ptr. A winner may hold lock
// for up to MAX_BURST back-to-back beats. clr zeroes q without touching
// arbitration.
module reg8_rr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           lock,
  input  logic [N*W-1:0]         wdata,
  input  logic                   clr,
  output logic [N-1:0]           gnt,
  output logic [W-1:0]           q,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   owner
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [CW-1:0] beat;

  logic          found;
  logic [OW-1:0] winner;
  logic [W-1:0]  own_data;
  logic          own_req;
  logic          own_lock;
  logic          cont;
  logic [OW-1:0] next_ptr;

  // Rotating priority search: first set req bit at ptr, ptr+1, ... modulo N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

  // Select the current owner's data, request and lock bits.
  always_comb begin
    own_data = '0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (OW'(i) == owner) begin
        own_data = wdata[i*W +: W];
        own_req  = req[i];
        own_lock = lock[i];
      end
    end
  end

  // Burst continues only while the owner still requests, locks and has beats left.
  always_comb begin
    cont     = own_req && own_lock && (beat < CW'(MAX_BURST - 1));
    next_ptr = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
  end

  // Arbitration FSM with registered grant, owner, busy and stored value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      beat  <= '0;
      gnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state  <= WRITE;
            gnt    <= '0;
            gnt[winner] <= 1'b1;
            owner  <= winner;
            beat   <= '0;
            busy   <= 1'b1;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        WRITE: begin
          q <= own_data;
          if (cont) begin
            beat <= beat + 1'b1;
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
      // clr wins over a concurrent write beat; the beat is still acknowledged.
      if (clr) begin
        q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg8_rr_arbiter.sv
// Directed bench for reg8_rr_arbiter (N=4, W=8, MAX_BURST=4).
module tb_reg8_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic        clr;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        busy;
  logic [1:0]  owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  egnt;
    logic [7:0]  eq;
    logic        ebusy;
    logic [1:0]  eown;
  } vec_t;

  vec_t vecs[$];

  reg8_rr_arbiter #(.N(4), .W(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .clr   (clr),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .owner (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                         input logic eb, input logic [1:0] eo);
    chk({tag, " gnt"},   32'(gnt),   32'(eg));
    chk({tag, " q"},     32'(q),     32'(eq));
    chk({tag, " busy"},  32'(busy),  32'(eb));
    chk({tag, " owner"}, 32'(owner), 32'(eo));
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                              input logic c, input logic [3:0] eg, input logic [7:0] eq,
                              input logic eb, input logic [1:0] eo);
    vec_t v;
    v.req = r; v.lock = l; v.wdata = d; v.clr = c;
    v.egnt = eg; v.eq = eq; v.ebusy = eb; v.eown = eo;
    vecs.push_back(v);
  endfunction

  localparam logic [31:0] D0 = 32'h44332211;

  initial begin
    // rotation, ptr starts at 0
    add(4'hF, 4'h0, D0, 0, 4'h1, 8'h00, 1, 0);
    add(4'hF, 4'h0, D0, 0, 4'h0, 8'h11, 0, 0);
    add(4'hF, 4'h0, D0, 0, 4'h2, 8'h11, 1, 1);
    add(4'hF, 4'h0, D0, 0, 4'h0, 8'h22, 0, 1);
    add(4'hF, 4'h0, D0, 0, 4'h4, 8'h22, 1, 2);
    add(4'hF, 4'h0, D0, 0, 4'h0, 8'h33, 0, 2);
    add(4'hF, 4'h0, D0, 0, 4'h8, 8'h33, 1, 3);
    add(4'hF, 4'h0, D0, 0, 4'h0, 8'h44, 0, 3);
    add(4'hF, 4'h0, D0, 0, 4'h1, 8'h44, 1, 0);
    add(4'hF, 4'h0, D0, 0, 4'h0, 8'h11, 0, 0);
    // burst cap on requester 2, clr mid-burst leaves gnt alone
    add(4'h4, 4'h4, D0, 0, 4'h4, 8'h11, 1, 2);
    add(4'h4, 4'h4, D0, 0, 4'h4, 8'h33, 1, 2);
    add(4'h4, 4'h4, D0, 1, 4'h4, 8'h00, 1, 2);
    add(4'h4, 4'h4, D0, 0, 4'h4, 8'h33, 1, 2);
    add(4'h4, 4'h4, D0, 0, 4'h0, 8'h33, 0, 2);
    add(4'h4, 4'h4, D0, 0, 4'h4, 8'h33, 1, 2);
    // clear collision with A5 on the final beat
    add(4'h4, 4'h0, 32'h44A52211, 1, 4'h0, 8'h00, 0, 2);
    // lock in IDLE ignored
    add(4'h0, 4'hF, D0, 0, 4'h0, 8'h00, 0, 2);
    // hold-off: ptr=3, req=0011, requester 0 locks a full burst
    add(4'h3, 4'h1, D0, 0, 4'h1, 8'h00, 1, 0);
    add(4'h3, 4'h1, D0, 0, 4'h1, 8'h11, 1, 0);
    add(4'h3, 4'h1, D0, 0, 4'h1, 8'h11, 1, 0);
    add(4'h3, 4'h1, D0, 0, 4'h1, 8'h11, 1, 0);
    add(4'h3, 4'h1, D0, 0, 4'h0, 8'h11, 0, 0);
    // early release: requester 1 drops lock in its second beat
    add(4'h7, 4'h2, D0, 0, 4'h2, 8'h11, 1, 1);
    add(4'h7, 4'h2, D0, 0, 4'h2, 8'h22, 1, 1);
    add(4'h7, 4'h0, 32'h44336611, 0, 4'h0, 8'h66, 0, 1);
    add(4'h7, 4'h4, D0, 0, 4'h4, 8'h66, 1, 2);
    add(4'h7, 4'h4, D0, 0, 4'h4, 8'h33, 1, 2);

    reset = 1'b1; req = '0; lock = '0; wdata = D0; clr = 1'b0;
    #1;
    chk_all("reset", 4'h0, 8'h00, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      req = vecs[i].req; lock = vecs[i].lock; wdata = vecs[i].wdata; clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].egnt, vecs[i].eq, vecs[i].ebusy, vecs[i].eown);
    end

    // asynchronous reset in the middle of requester 2's burst
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 4'h0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk_all("held_reset", 4'h0, 8'h00, 0, 0);
    @(negedge clk);
    reset = 1'b0; req = 4'hF; lock = 4'h0; clr = 1'b0; wdata = D0;
    @(posedge clk);
    #1;
    chk_all("post_reset_grant", 4'h1, 8'h00, 1, 0);
    @(posedge clk);
    #1;
    chk_all("post_reset_write", 4'h0, 8'h11, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
